// File: rtl/reg_load_sequencer.sv
// Reload sequencer for a bank of edge-loaded registers.
// Each pass takes one word from the random source per register, puts it on
// the shared data bus, then pulses that register's load strobe.
module reg_load_sequencer #(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned PERIOD    = 50_000_000,
    parameter int unsigned PULSE_LEN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                manual_req,
    input  logic [WIDTH:0]      rnd_in,
    input  logic                rnd_valid,
    output logic                rnd_ack,
    output logic [WIDTH:0]      data_out,
    output logic [NUM_REGS-1:0] load_en,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned CNTW = $clog2(PERIOD);
    localparam int unsigned PLW  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REGS - 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(PERIOD - 1);
    localparam logic [PLW-1:0]  LAST_PL  = PLW'(PULSE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [PLW-1:0]  pl_q, pl_d;
    logic            pend_q, pend_d;
    logic [WIDTH:0]  data_q, data_d;

    // State and datapath registers; async reset clears everything including the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pl_q    <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pl_q    <= pl_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
        end
    end

    // Next-state and output decode; strobes and status come straight from state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pl_d       = pl_q;
        pend_d     = pend_q;
        data_d     = data_q;
        rnd_ack    = 1'b0;
        load_en    = '0;
        busy       = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (manual_req) begin
                    state_d = S_SETUP;
                end else if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end

            S_WAIT: begin
                if (manual_req) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end else if (!start) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_SETUP: begin
                busy   = 1'b1;
                pend_d = pend_q | manual_req;
                if (rnd_valid) begin
                    rnd_ack = 1'b1;
                    data_d  = rnd_in;
                    pl_d    = '0;
                    state_d = S_STROBE;
                end
            end

            S_STROBE: begin
                busy           = 1'b1;
                pend_d         = pend_q | manual_req;
                load_en[idx_q] = 1'b1;
                if (pl_q == LAST_PL) begin
                    state_d = S_HOLD;
                end else begin
                    pl_d = pl_q + 1'b1;
                end
            end

            S_HOLD: begin
                busy   = 1'b1;
                pend_d = pend_q | manual_req;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SETUP;
                end
            end

            S_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                idx_d      = '0;
                // A request landing in DONE itself counts as pending so it is not lost.
                if (pend_q || manual_req) begin
                    pend_d  = 1'b0;
                    state_d = S_SETUP;
                end else if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Self-checking bench for reg_load_sequencer (2 regs, 10-bit bus, period 10, pulse 2).
module tb_reg_load_sequencer;

    localparam int N    = 2;
    localparam int W    = 9;
    localparam int PER  = 10;
    localparam int PL   = 2;
    localparam int OW   = N + W + 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           manual_req = 1'b0;
    logic [W:0]     rnd_in = '0;
    logic           rnd_valid = 1'b0;
    logic           rnd_ack;
    logic [W:0]     data_out;
    logic [N-1:0]   load_en;
    logic           busy;
    logic           frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    reg_load_sequencer #(
        .NUM_REGS (N),
        .WIDTH    (W),
        .PERIOD   (PER),
        .PULSE_LEN(PL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .manual_req(manual_req),
        .rnd_in    (rnd_in),
        .rnd_valid (rnd_valid),
        .rnd_ack   (rnd_ack),
        .data_out  (data_out),
        .load_en   (load_en),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Edge-loaded register bank and one-hot monitor, sampled on the idle clock edge.
    logic [W:0]   ereg0 = '1;
    logic [W:0]   ereg1 = '1;
    logic [N-1:0] ld_prev = '0;
    int           onehot_viol = 0;

    always @(negedge clk) begin
        if (!$onehot0(load_en)) onehot_viol++;
        if (load_en[0] && !ld_prev[0]) ereg0 = data_out;
        if (load_en[1] && !ld_prev[1]) ereg1 = data_out;
        ld_prev = load_en;
    end

    // Reference model: a per-cycle schedule of driven inputs and expected outputs,
    // built from pass-level rules (stall, ack, PL strobes, hold, ..., done).
    typedef struct packed {
        logic         vld;
        logic         st;
        logic         man;
        logic         ack;
        logic [N-1:0] ld;
        logic         fd;
        logic         busy;
        logic [W:0]   data;
    } ent_t;

    ent_t       sched[$];
    logic [W:0] wbank[256];
    int         mcons;
    logic [W:0] mdata;
    int         acks;

    task automatic push(input bit vld, input bit st, input bit man, input bit ack,
                        input logic [N-1:0] ld, input bit fd, input bit bsy);
        ent_t e;
        e.vld = vld; e.st = st; e.man = man; e.ack = ack;
        e.ld = ld; e.fd = fd; e.busy = bsy; e.data = mdata;
        sched.push_back(e);
    endtask

    task automatic model_idle(input int n, input bit st, input bit man_last);
        for (int i = 0; i < n; i++) push(1'b1, st, man_last && (i == n - 1), 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic model_pass(input int stall0, input int stall1,
                              input logic [63:0] st_mask, input logic [63:0] man_mask);
        int k;
        int stall[N];
        k = 0;
        stall[0] = stall0;
        stall[1] = stall1;
        for (int r = 0; r < N; r++) begin
            for (int s = 0; s < stall[r]; s++) begin
                push(1'b0, st_mask[k], man_mask[k], 1'b0, '0, 1'b0, 1'b1); k++;
            end
            push(1'b1, st_mask[k], man_mask[k], 1'b1, '0, 1'b0, 1'b1); k++;
            mdata = wbank[mcons];
            mcons++;
            for (int p = 0; p < PL; p++) begin
                push(1'b1, st_mask[k], man_mask[k], 1'b0, N'(1) << r, 1'b0, 1'b1); k++;
            end
            push(1'b1, st_mask[k], man_mask[k], 1'b0, '0, 1'b0, 1'b1); k++;
        end
        push(1'b1, st_mask[k], man_mask[k], 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic fill_bank();
        for (int i = 0; i < 256; i++) wbank[i] = (W + 1)'($urandom);
    endtask

    task automatic do_reset();
        start = 1'b0; manual_req = 1'b0; rnd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdata = '0; mcons = 0; acks = 0;
        sched.delete();
    endtask

    task automatic test_reset();
        ent_t e;
        logic [OW-1:0] obs, exp;
        rnd_valid = 1'b1;
        #2;
        n_assert++;
        if ({rnd_ack, load_en, frame_done, busy, data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b ld=%b fd=%b busy=%b data=%h, expected all 0",
                     rnd_ack, load_en, frame_done, busy, data_out);
        end
        @(posedge clk); #1;
        do_reset();
        rnd_valid = 1'b1;
        model_idle(6, 1'b0, 1'b0);
        while (sched.size() > 0) begin
            e = sched.pop_front();
            start = e.st; manual_req = e.man; rnd_valid = e.vld; rnd_in = wbank[acks];
            #1;
            obs = {rnd_ack, load_en, frame_done, busy, data_out};
            exp = {e.ack, e.ld, e.fd, e.busy, e.data};
            n_assert++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_idle: got %b, expected %b", obs, exp);
            end
            if (rnd_ack) acks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_periodic();
        ent_t e;
        logic [OW-1:0] obs, exp;
        do_reset();
        fill_bank();
        wbank[0] = 10'h155;
        wbank[1] = 10'h0AA;
        model_idle(1, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++) begin
            model_idle(PER, 1'b1, 1'b0);
            model_pass(0, 0, '1, '0);
        end
        while (sched.size() > 0) begin
            e = sched.pop_front();
            start = e.st; manual_req = e.man; rnd_valid = e.vld; rnd_in = wbank[acks];
            #1;
            obs = {rnd_ack, load_en, frame_done, busy, data_out};
            exp = {e.ack, e.ld, e.fd, e.busy, e.data};
            n_assert++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL periodic: got ack,ld,fd,busy,data=%b, expected %b", obs, exp);
            end
            if (rnd_ack) acks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        ent_t e;
        logic [OW-1:0] obs, exp;
        do_reset();
        fill_bank();
        model_idle(1, 1'b0, 1'b1);
        model_pass(5, int'($urandom_range(0, 3)), '0, '0);
        model_idle(5, 1'b0, 1'b0);
        model_idle(1, 1'b0, 1'b1);
        model_pass(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), '0, '0);
        model_idle(4, 1'b0, 1'b0);
        while (sched.size() > 0) begin
            e = sched.pop_front();
            start = e.st; manual_req = e.man; rnd_valid = e.vld; rnd_in = wbank[acks];
            #1;
            obs = {rnd_ack, load_en, frame_done, busy, data_out};
            exp = {e.ack, e.ld, e.fd, e.busy, e.data};
            n_assert++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stall: got ack,ld,fd,busy,data=%b, expected %b", obs, exp);
            end
            if (rnd_ack) acks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_manual();
        ent_t e;
        logic [OW-1:0] obs, exp;
        logic [63:0] mm;
        do_reset();
        fill_bank();
        mm = (64'd1 << $urandom_range(0, 3)) | (64'd1 << $urandom_range(4, 7));
        model_idle(1, 1'b1, 1'b0);
        model_idle(4, 1'b1, 1'b1);
        model_pass(0, 0, '1, mm);
        model_pass(0, 0, '1, '0);
        model_idle(PER, 1'b1, 1'b0);
        model_pass(0, 0, '1, '0);
        model_idle(3, 1'b0, 1'b0);
        while (sched.size() > 0) begin
            e = sched.pop_front();
            start = e.st; manual_req = e.man; rnd_valid = e.vld; rnd_in = wbank[acks];
            #1;
            obs = {rnd_ack, load_en, frame_done, busy, data_out};
            exp = {e.ack, e.ld, e.fd, e.busy, e.data};
            n_assert++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL manual: got ack,ld,fd,busy,data=%b, expected %b", obs, exp);
            end
            if (rnd_ack) acks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stop();
        ent_t e;
        logic [OW-1:0] obs, exp;
        do_reset();
        fill_bank();
        model_idle(1, 1'b1, 1'b0);
        model_idle(PER, 1'b1, 1'b0);
        model_pass(0, 0, 64'h3, '0);
        model_idle(PER + 3, 1'b0, 1'b0);
        while (sched.size() > 0) begin
            e = sched.pop_front();
            start = e.st; manual_req = e.man; rnd_valid = e.vld; rnd_in = wbank[acks];
            #1;
            obs = {rnd_ack, load_en, frame_done, busy, data_out};
            exp = {e.ack, e.ld, e.fd, e.busy, e.data};
            n_assert++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stop: got ack,ld,fd,busy,data=%b, expected %b", obs, exp);
            end
            if (rnd_ack) acks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_edge_regs();
        ent_t e;
        do_reset();
        fill_bank();
        wbank[0] = 10'h155;
        wbank[1] = 10'h0AA;
        model_idle(1, 1'b0, 1'b1);
        model_pass(0, 0, '0, '0);
        model_idle(2, 1'b0, 1'b0);
        while (sched.size() > 0) begin
            e = sched.pop_front();
            start = e.st; manual_req = e.man; rnd_valid = e.vld; rnd_in = wbank[acks];
            #1;
            n_assert++;
            if (load_en !== e.ld) begin
                n_fail++;
                $display("FAIL edge_strobe: load_en=%b, expected %b", load_en, e.ld);
            end
            if (rnd_ack) acks++;
            @(posedge clk); #1;
        end
        n_assert++;
        if ({ereg0, ereg1} !== {10'h155, 10'h0AA}) begin
            n_fail++;
            $display("FAIL edge_regs: reg0=%h reg1=%h, expected 155 0aa", ereg0, ereg1);
        end
        n_assert++;
        if (onehot_viol !== 0) begin
            n_fail++;
            $display("FAIL onehot: %0d cycles with >1 load_en bit, expected 0", onehot_viol);
        end
    endtask

    task automatic test_reset_mid_strobe();
        logic [W:0] w;
        do_reset();
        w = (W + 1)'($urandom);
        while (w == 10'h155) w = (W + 1)'($urandom);
        rnd_in = w; rnd_valid = 1'b1; start = 1'b0;
        manual_req = 1'b1;
        @(posedge clk); #1;
        manual_req = 1'b0;
        @(posedge clk); #1;
        n_assert++;
        if ({load_en, data_out} !== {2'b01, w}) begin
            n_fail++;
            $display("FAIL mid_strobe_entry: ld=%b data=%h, expected 01 %h", load_en, data_out, w);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_assert++;
        if ({load_en, data_out, busy, frame_done, rnd_ack} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: ld=%b data=%h busy=%b fd=%b ack=%b, expected all 0",
                     load_en, data_out, busy, frame_done, rnd_ack);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_assert++;
            if ({load_en, busy, rnd_ack} !== '0) begin
                n_fail++;
                $display("FAIL post_reset_idle: ld=%b busy=%b ack=%b, expected 0", load_en, busy, rnd_ack);
            end
            @(posedge clk); #1;
        end
        n_assert++;
        if ({ereg0, ereg1} !== {w, 10'h0AA}) begin
            n_fail++;
            $display("FAIL reset_keeps_regs: reg0=%h reg1=%h, expected %h 0aa", ereg0, ereg1, w);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_stall();
        test_manual();
        test_stop();
        test_edge_regs();
        test_reset_mid_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
